// File: rtl/stage_m.sv
// Memory stage: E/M pipeline register, data-memory request/ack handshake, store lane
// replication and load alignment. Build option: STAGE_M_MISALIGN_EN traps misaligned accesses.
module stage_m #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        MemSignedE,
  input  logic        armE,
  input  logic [1:0]  MemSizeE,
  output logic [31:0] ALUResultM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic [1:0]  ResultSrcM,
  output logic        armM,
  output logic        RegWriteM,
  output logic [31:0] DataAdrM,
  output logic [31:0] WriteDataM,
  output logic [3:0]  ByteEnM,
  output logic        MemReqM,
  output logic        MemWeM,
  input  logic        MemAckM,
  input  logic [31:0] ReadDataM,
  output logic [31:0] LoadDataM,
  output logic        StallM,
  output logic        MemErrM
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [31:0] write_data_q;
  logic        reg_write_q;
  logic        mem_write_q;
  logic        mem_signed_q;
  logic [1:0]  mem_size_q;

  logic        memop;
  logic        misalign;
  logic        timeout_err;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic [1:0]  addr_lo;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // The E/M register freezes while an access is outstanding so the address,
  // data and enables stay stable for the memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALUResultM   <= '0;
      PCPlus4M     <= '0;
      RdM          <= '0;
      ResultSrcM   <= '0;
      armM         <= 1'b0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_signed_q <= 1'b0;
      mem_size_q   <= '0;
    end else if (!StallM) begin
      ALUResultM   <= ALUResultE;
      PCPlus4M     <= PCPlus4E;
      RdM          <= RdE;
      ResultSrcM   <= ResultSrcE;
      armM         <= armE;
      write_data_q <= WriteDataE;
      reg_write_q  <= RegWriteE;
      mem_write_q  <= MemWriteE;
      mem_signed_q <= MemSignedE;
      mem_size_q   <= MemSizeE;
    end
  end

  // Handshake FSM: IDLE issues the request; WAIT counts unacknowledged cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemReqM && !MemAckM) begin
            state    <= WAIT;
            wait_cnt <= 8'd1;
          end
        end
        WAIT: begin
          if (MemAckM || timeout_err) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  assign memop   = mem_write_q | (ResultSrcM == 2'b01);
  assign addr_lo = ALUResultM[1:0];
  assign is_byte = (mem_size_q == 2'b00);
  assign is_half = (mem_size_q == 2'b01);
  assign is_word = mem_size_q[1];

`ifdef STAGE_M_MISALIGN_EN
  assign misalign = memop & ((is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // An ack in the final wait cycle still wins over the timeout.
  assign timeout_err = (state == WAIT) & (wait_cnt == TIMEOUT_CNT) & ~MemAckM;
  assign MemErrM     = timeout_err | misalign;
  assign MemReqM     = (state == WAIT) | (memop & ~misalign);
  assign StallM      = memop & ~MemAckM & ~MemErrM;
  assign RegWriteM   = reg_write_q & ~StallM & ~misalign;
  assign MemWeM      = mem_write_q & MemReqM;
  assign DataAdrM    = {ALUResultM[31:2], 2'b00};

  always_comb begin
    ByteEnM = 4'b0000;
    if (MemReqM) begin
      if (is_byte)      ByteEnM = 4'b0001 << addr_lo;
      else if (is_half) ByteEnM = addr_lo[1] ? 4'b1100 : 4'b0011;
      else              ByteEnM = 4'b1111;
    end
  end

  always_comb begin
    WriteDataM = write_data_q;
    if (is_byte)      WriteDataM = {4{write_data_q[7:0]}};
    else if (is_half) WriteDataM = {2{write_data_q[15:0]}};
  end

  always_comb begin
    case (addr_lo)
      2'd0:    load_byte = ReadDataM[7:0];
      2'd1:    load_byte = ReadDataM[15:8];
      2'd2:    load_byte = ReadDataM[23:16];
      default: load_byte = ReadDataM[31:24];
    endcase
    load_half = addr_lo[1] ? ReadDataM[31:16] : ReadDataM[15:0];
    LoadDataM = ReadDataM;
    if (is_byte)      LoadDataM = {{24{mem_signed_q & load_byte[7]}}, load_byte};
    else if (is_half) LoadDataM = {{16{mem_signed_q & load_half[15]}}, load_half};
    if (MemErrM)      LoadDataM = '0;
  end

endmodule
